// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI controller.
package jstk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    GAP,
    DONE
  } state_t;

  localparam int unsigned NUM_BYTES     = 5;
  localparam logic [5:0]  CMD_PREFIX    = 6'b100000;

  localparam int unsigned SCLK_HALF_DEF = 50;
  localparam int unsigned SS_SETUP_DEF  = 1500;
  localparam int unsigned BYTE_GAP_DEF  = 1000;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One 8-bit SPI mode-0 exchange: SCLK idles low, MISO sampled on the rise,
// MOSI advanced on the fall, MSB first.
module spi_byte_xfer
  import jstk_pkg::*;
#(
  parameter int unsigned SCLK_HALF = SCLK_HALF_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam int unsigned   CW        = $clog2(SCLK_HALF) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          half_end;

  // done is combinational so the caller sees it on the same edge SCLK falls
  always_comb begin
    half_end = active && (cnt == HALF_LAST);
    done     = half_end && sclk && (bit_cnt == 3'd7);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rx_byte <= '0;
    end else if (start) begin
      active  <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= tx_byte[7];
      sh      <= {tx_byte[6:0], 1'b0};
    end else if (active) begin
      if (half_end) begin
        cnt <= '0;
        if (!sclk) begin
          sclk    <= 1'b1;
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 3'd1;
          mosi    <= (bit_cnt == 3'd7) ? 1'b0 : sh[7];
          sh      <= {sh[6:0], 1'b0};
          if (bit_cnt == 3'd7) active <= 1'b0;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jstk_spi_ctrl.sv
// PmodJSTK SPI master: one 5-byte exchange per SND_REC rising edge.
// Define JSTK_MISO_SYNC_EN to pass MISO through a 2-flop synchronizer.
module jstk_spi_ctrl
  import jstk_pkg::*;
#(
  parameter int unsigned SCLK_HALF = SCLK_HALF_DEF,
  parameter int unsigned SS_SETUP  = SS_SETUP_DEF,
  parameter int unsigned BYTE_GAP  = BYTE_GAP_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SND_REC,
  input  logic [1:0] LED,
  input  logic       MISO,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  output logic       BUSY,
  output logic [9:0] X_POS,
  output logic [9:0] Y_POS,
  output logic [2:0] BTNS,
  output logic       VALID
);

  localparam int unsigned   CW         = cnt_width(SS_SETUP, BYTE_GAP, SCLK_HALF);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);
  localparam logic [2:0]    LAST_IDX   = 3'(NUM_BYTES - 1);

  state_t        state, state_n;
  logic          snd_q;
  logic          trigger;
  logic [CW-1:0] cnt;
  logic          setup_last, gap_last;
  logic [2:0]    idx;
  logic [7:0]    tx_byte;
  logic [7:0]    rx_byte;
  logic          byte_done;
  logic          start;
  logic          miso_s;
  logic [9:0]    x_stage, y_stage;

`ifdef JSTK_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge CLK) begin
    if (RST) miso_sync <= '0;
    else     miso_sync <= {miso_sync[0], MISO};
  end
  assign miso_s = miso_sync[1];
`else
  assign miso_s = MISO;
`endif

  always_comb begin
    trigger    = SND_REC & ~snd_q;
    setup_last = (cnt == SETUP_LAST);
    gap_last   = (cnt == GAP_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (trigger) state_n = SETUP;
      SETUP:   if (setup_last) state_n = XFER;
      XFER:    if (byte_done) state_n = (idx == LAST_IDX) ? DONE : GAP;
      GAP:     if (gap_last) state_n = XFER;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    SS    = 1'b1;
    BUSY  = 1'b0;
    VALID = 1'b0;
    start = 1'b0;
    case (state)
      SETUP: begin SS = 1'b0; BUSY = 1'b1; start = setup_last; end
      XFER:  begin SS = 1'b0; BUSY = 1'b1; end
      GAP:   begin SS = 1'b0; BUSY = 1'b1; start = gap_last; end
      DONE:  VALID = 1'b1;
      default: ;
    endcase
  end

  // Position halves are staged as each byte lands; results publish with byte 4
  always_ff @(posedge CLK) begin
    if (RST) begin
      snd_q   <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      tx_byte <= '0;
      x_stage <= '0;
      y_stage <= '0;
      X_POS   <= '0;
      Y_POS   <= '0;
      BTNS    <= '0;
    end else begin
      snd_q <= SND_REC;
      if ((state == SETUP && !setup_last) || (state == GAP && !gap_last))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;

      if (state == IDLE && trigger) begin
        tx_byte <= {CMD_PREFIX, LED};
        idx     <= '0;
      end

      if (state == XFER && byte_done) begin
        case (idx)
          3'd0:    x_stage[7:0] <= rx_byte;
          3'd1:    x_stage[9:8] <= rx_byte[1:0];
          3'd2:    y_stage[7:0] <= rx_byte;
          3'd3:    y_stage[9:8] <= rx_byte[1:0];
          default: begin
            X_POS <= x_stage;
            Y_POS <= y_stage;
            BTNS  <= rx_byte[2:0];
          end
        endcase
        if (idx != LAST_IDX) begin
          idx     <= idx + 3'd1;
          tx_byte <= '0;
        end
      end
    end
  end

  spi_byte_xfer #(
    .SCLK_HALF(SCLK_HALF)
  ) u_xfer (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .tx_byte (tx_byte),
    .miso    (miso_s),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .rx_byte (rx_byte),
    .done    (byte_done)
  );

endmodule
